branch_predictor_bht: RTL and testbench
=======================================

# branch_predictor_bht

Parametrised branch history table plus branch target buffer for the pipelined RV32I core. It replaces the single global 2-bit counter with a direct-mapped, tagged, per-PC table of saturating counters and stored targets. The IF stage queries it combinationally for next-PC selection. The EX stage returns resolved outcomes, which yields a same-cycle mispredict/redirect indication and a registered table update.

## Interface
- `ENTRIES`, 64: table depth; power of two, ≥2; `IDX = log2(ENTRIES)`.
- `CTR_BITS`, 2: saturating counter width, ≥1.
- `TAG_BITS`, 8: tag width; `IDX+TAG_BITS ≤ 30`.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_lookup_pc` in 32: PC being fetched (IF stage).
- `o_pred_hit` out 1: valid entry with matching tag.
- `o_pred_taken` out 1: predict taken.
- `o_pred_target` out 32: predicted next PC.
- `i_upd_valid` in 1: resolved conditional branch or JAL/JALR in EX this cycle.
- `i_upd_pc` in 32: PC of the resolved instruction.
- `i_upd_taken` in 1: actual outcome.
- `i_upd_target` in 32: actual taken target.
- `i_upd_pred_taken` in 1: prediction carried down the pipeline with the instruction.
- `i_upd_pred_target` in 32: predicted next PC carried with the instruction.
- `i_flush` in 1: invalidate whole table (fence.i / instruction-memory reload in setup).
- `o_mispredict` out 1: flush IF/ID and ID/EX; redirect.
- `o_redirect_pc` out 32: correct next PC when `o_mispredict`.
- `o_branch_count` out 32: resolved updates since reset.
- `o_mispredict_count` out 32: mispredicts since reset.

## Operation
- Index = `pc[IDX+1:2]`. Tag = `pc[IDX+TAG_BITS+1:IDX+2]`. Entry = {valid, tag, ctr[CTR_BITS], target[32]}, held in flops.
- Lookup is purely combinational from current table state.
  - Hit: entry valid and tag matches.
  - `o_pred_taken` = hit & ctr MSB.
  - `o_pred_target` = taken ? stored target : `i_lookup_pc + 4` (32-bit wrap).
- Mispredict, combinational, only when `i_upd_valid`. Fires if `i_upd_taken != i_upd_pred_taken`, or if both are taken and `i_upd_target != i_upd_pred_target`.
- `o_redirect_pc` = `i_upd_taken` ? `i_upd_target` : `i_upd_pc + 4`. It is 0 when `o_mispredict` is 0.
- Update on the clock edge when `i_upd_valid`, addressing the entry by `i_upd_pc`:
  - Hit, taken: ctr++ saturating at 2^CTR_BITS−1; target ← `i_upd_target`.
  - Hit, not taken: ctr−− saturating at 0; target unchanged.
  - Miss, taken: allocate. valid←1, tag←new, ctr←2^(CTR_BITS−1) (weakly taken), target←`i_upd_target`. Overwrites any victim.
  - Miss, not taken: no change.
- Perf counters, both 32-bit and wrapping:
  - `o_branch_count` += 1 per `i_upd_valid`.
  - `o_mispredict_count` += 1 per `o_mispredict`.
- `i_flush`: all valid bits ← 0 on the edge. Counters and perf counters are unchanged.

## Timing
- Reset values: all valid=0, all ctr=0, all targets=0, both perf counters=0.
  - After reset: `o_pred_hit`=0, `o_pred_taken`=0, `o_pred_target`=`i_lookup_pc+4`.
  - `o_mispredict`=0 and `o_redirect_pc`=0 while `i_upd_valid`=0.
- Lookup latency: 0 cycles. Update visible to lookup: the cycle after the update edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update state. No bypass.
- Precedence on one edge: `rst` > `i_flush` > update. With flush+update in the same cycle, the table ends all-invalid, but the perf counters still count the update.
- `rst` asserted mid-stream discards any in-flight update. `o_mispredict` remains combinational during reset, but its count is not recorded.
- Updates with `i_upd_valid`=0 are ignored regardless of other inputs.

## Test plan
- Reset, then lookup 0x0000_0100 → hit=0, taken=0, target=0x0000_0104; both counters 0.
- Update pc=0x100, taken=1, target=0x40, pred_taken=0 → mispredict=1, redirect=0x40. Next cycle, lookup 0x100 → hit=1, taken=1, target=0x40; mispredict_count=1.
- Counter saturation at CTR_BITS=2 for pc=0x100:
  - After the allocation above, three more taken updates → ctr=3.
  - Then one not-taken → ctr=2, still predicts taken.
  - Second not-taken → ctr=1, predicts not taken, target=0x104.
  - Not-taken at ctr=0 → ctr stays 0.
- Aliasing with ENTRIES=64: entry for 0x100 is valid; taken update at 0x100+256 (same index, different tag) evicts it. Lookup 0x100 → hit=0.
- Same taken/target as prediction (taken, 0x40 vs 0x40) → mispredict=0. Predicted target 0x44 vs actual 0x40 → mispredict=1, redirect=0x40.
- Flush and update to 0x200 in the same cycle → next cycle all lookups miss; branch_count incremented by 1.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// Direct-mapped, tagged branch history table with per-entry target buffer.
// Combinational IF-stage lookup; EX-stage resolution gives same-cycle redirect and a registered update.
module branch_predictor_bht #(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_lookup_pc,
  output logic        o_pred_hit,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  input  logic        i_flush,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_branch_count,
  output logic [31:0] o_mispredict_count
);

  localparam int IDX = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic [IDX-1:0]      lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [IDX-1:0]      up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;

  assign lk_idx = i_lookup_pc[IDX+1:2];
  assign lk_tag = i_lookup_pc[IDX+TAG_BITS+1:IDX+2];
  assign up_idx = i_upd_pc[IDX+1:2];
  assign up_tag = i_upd_pc[IDX+TAG_BITS+1:IDX+2];

  // Lookup reads the registered table only, so a same-cycle update is never bypassed.
  always_comb begin
    o_pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    o_pred_taken  = o_pred_hit && ctr_q[lk_idx][CTR_BITS-1];
    o_pred_target = o_pred_taken ? target_q[lk_idx] : i_lookup_pc + 32'd4;
  end

  always_comb begin
    up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    o_mispredict  = i_upd_valid &&
                    ((i_upd_taken != i_upd_pred_taken) ||
                     (i_upd_taken && i_upd_pred_taken && (i_upd_target != i_upd_pred_target)));
    o_redirect_pc = '0;
    if (o_mispredict)
      o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;
  end

  // NOTE: the whole table lives in flops and is cleared on reset, so it cannot map to a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (i_upd_valid) begin
      if (up_hit) begin
        if (i_upd_taken) begin
          if (ctr_q[up_idx] != CTR_MAX) ctr_q[up_idx] <= ctr_q[up_idx] + 1'b1;
          target_q[up_idx] <= i_upd_target;
        end else if (ctr_q[up_idx] != '0) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - 1'b1;
        end
      end else if (i_upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        ctr_q[up_idx]    <= CTR_WEAK;
        target_q[up_idx] <= i_upd_target;
      end
    end
  end

  // Perf counters ignore flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_branch_count     <= '0;
      o_mispredict_count <= '0;
    end else begin
      if (i_upd_valid)  o_branch_count     <= o_branch_count + 32'd1;
      if (o_mispredict) o_mispredict_count <= o_mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht (default 64 entries, 2-bit counters, 8-bit tags).
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_lookup_pc;
  logic        o_pred_hit;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_pred_taken;
  logic [31:0] i_upd_pred_target;
  logic        i_flush;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
  logic [31:0] o_branch_count;
  logic [31:0] o_mispredict_count;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_predictor_bht dut (
    .clk               (clk),
    .rst               (rst),
    .i_lookup_pc       (i_lookup_pc),
    .o_pred_hit        (o_pred_hit),
    .o_pred_taken      (o_pred_taken),
    .o_pred_target     (o_pred_target),
    .i_upd_valid       (i_upd_valid),
    .i_upd_pc          (i_upd_pc),
    .i_upd_taken       (i_upd_taken),
    .i_upd_target      (i_upd_target),
    .i_upd_pred_taken  (i_upd_pred_taken),
    .i_upd_pred_target (i_upd_pred_target),
    .i_flush           (i_flush),
    .o_mispredict      (o_mispredict),
    .o_redirect_pc     (o_redirect_pc),
    .o_branch_count    (o_branch_count),
    .o_mispredict_count(o_mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic hit, input logic tkn, input logic [31:0] tgt);
    i_lookup_pc = pc;
    #1;
    check1({tag, "_hit"}, o_pred_hit, hit);
    check1({tag, "_taken"}, o_pred_taken, tkn);
    check32({tag, "_target"}, o_pred_target, tgt);
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tkn, input logic [31:0] tgt,
                         input logic ptkn, input logic [31:0] ptgt);
    i_upd_valid       = 1'b1;
    i_upd_pc          = pc;
    i_upd_taken       = tkn;
    i_upd_target      = tgt;
    i_upd_pred_taken  = ptkn;
    i_upd_pred_target = ptgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    i_upd_valid = 1'b0;
    i_flush     = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic counts(input string tag, input logic [31:0] br, input logic [31:0] mp);
    check32({tag, "_branch_count"}, o_branch_count, br);
    check32({tag, "_mispredict_count"}, o_mispredict_count, mp);
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_lookup_pc = 32'h100;
    i_upd_valid = 1'b0; i_upd_pc = '0; i_upd_taken = 1'b0; i_upd_target = '0;
    i_upd_pred_taken = 1'b0; i_upd_pred_target = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Reset state
    lookup("rst_lookup", 32'h100, 1'b0, 1'b0, 32'h104);
    counts("rst", 32'd0, 32'd0);
    check1("rst_mispredict", o_mispredict, 1'b0);
    check32("rst_redirect", o_redirect_pc, 32'h0);

    // Allocation; the same-cycle lookup still sees the old (empty) entry
    set_upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    check1("alloc_mispredict", o_mispredict, 1'b1);
    check32("alloc_redirect", o_redirect_pc, 32'h40);
    lookup("alloc_nobypass", 32'h100, 1'b0, 1'b0, 32'h104);
    tick();
    lookup("alloc_after", 32'h100, 1'b1, 1'b1, 32'h40);
    counts("alloc", 32'd1, 32'd1);

    // Three correctly predicted taken updates saturate the counter at 3
    for (int i = 0; i < 3; i++) begin
      set_upd(32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
      check1("sat_mispredict", o_mispredict, 1'b0);
      tick();
    end
    counts("sat", 32'd4, 32'd1);

    // 3 -> 2: still taken
    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
    check1("nt1_mispredict", o_mispredict, 1'b1);
    check32("nt1_redirect", o_redirect_pc, 32'h104);
    tick();
    lookup("ctr2", 32'h100, 1'b1, 1'b1, 32'h40);

    // 2 -> 1: hit but not taken
    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
    tick();
    lookup("ctr1", 32'h100, 1'b1, 1'b0, 32'h104);

    // 1 -> 0, then 0 stays 0; a taken update afterwards must land on 1 (not taken)
    set_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    check1("nt_correct_mispredict", o_mispredict, 1'b0);
    check32("nt_correct_redirect", o_redirect_pc, 32'h0);
    tick();
    set_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    tick();
    lookup("ctr0", 32'h100, 1'b1, 1'b0, 32'h104);
    set_upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    tick();
    lookup("ctr0_plus1", 32'h100, 1'b1, 1'b0, 32'h104);
    counts("ctr", 32'd9, 32'd4);

    // Aliasing: 0x200 shares index 0 with 0x100 but has a different tag
    set_upd(32'h200, 1'b1, 32'h80, 1'b0, 32'h204);
    tick();
    lookup("alias_victim", 32'h100, 1'b0, 1'b0, 32'h104);
    lookup("alias_new", 32'h200, 1'b1, 1'b1, 32'h80);
    counts("alias", 32'd10, 32'd5);

    // Target comparison for taken/taken, observed combinationally and then dropped
    set_upd(32'h300, 1'b1, 32'h40, 1'b1, 32'h40);
    check1("tgt_same_mispredict", o_mispredict, 1'b0);
    check32("tgt_same_redirect", o_redirect_pc, 32'h0);
    set_upd(32'h300, 1'b1, 32'h40, 1'b1, 32'h44);
    check1("tgt_diff_mispredict", o_mispredict, 1'b1);
    check32("tgt_diff_redirect", o_redirect_pc, 32'h40);
    i_upd_valid = 1'b0;
    #1;
    check1("invalid_mispredict", o_mispredict, 1'b0);
    check32("invalid_redirect", o_redirect_pc, 32'h0);

    // A clock with i_upd_valid low changes nothing
    i_upd_pc = 32'h400; i_upd_taken = 1'b1; i_upd_target = 32'h77;
    @(posedge clk); #1;
    lookup("ignored", 32'h400, 1'b0, 1'b0, 32'h404);
    counts("ignored", 32'd10, 32'd5);

    // Flush and update together: table empties but the update is counted
    set_upd(32'h200, 1'b1, 32'h90, 1'b1, 32'h80);
    i_flush = 1'b1;
    tick();
    lookup("flush_200", 32'h200, 1'b0, 1'b0, 32'h204);
    lookup("flush_100", 32'h100, 1'b0, 1'b0, 32'h104);
    counts("flush", 32'd11, 32'd6);

    // Reset mid-stream discards the in-flight update and clears the counters
    set_upd(32'h500, 1'b1, 32'h60, 1'b0, 32'h504);
    rst = 1'b1;
    #1;
    check1("rst_mid_mispredict", o_mispredict, 1'b1);
    tick();
    lookup("rst_mid", 32'h500, 1'b0, 1'b0, 32'h504);
    counts("rst_mid", 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
